ippcrc_crc_mch: RTL and testbench

//  Parametrised, pipelined multi-channel CRC generator/checker. Generalises the fixed CRC-12/8-bit

---
 rtl/ippcrc_pkg.sv | 30 +++
 rtl/ippcrc_crc_step.sv | 17 +
 rtl/ippcrc_crc_mch.sv | 65 ++++++
 tb/tb_ippcrc_crc_mch.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ippcrc_pkg.sv
// ippcrc_pkg: CRC polynomial constants plus generic bitswap and LFSR step functions sized up to 32-bit CRC / 64-bit data
package ippcrc_pkg;
    localparam int MAX_CRC = 32;
    localparam int MAX_DAT = 64;
    localparam logic [11:0] CRC12_POLY  = 12'h80F;
    localparam logic [15:0] CRC16_CCITT = 16'h1021;
    localparam logic [31:0] CRC32_POLY  = 32'h04C11DB7;

    function automatic logic [MAX_DAT-1:0] bitswap(input logic [MAX_DAT-1:0] d, input int w);
        logic [MAX_DAT-1:0] r;
        r = {<<{d}};
        return r >> (MAX_DAT - w);
    endfunction

    function automatic logic [MAX_CRC-1:0] crc_step(input logic [MAX_CRC-1:0] cur, input logic [MAX_DAT-1:0] d,
                                                     input int cw, input int dw, input logic [MAX_CRC-1:0] poly);
        logic [MAX_CRC-1:0] r, msk, top;
        logic fb;
        r   = cur;
        msk = (MAX_CRC'(1) << cw) - MAX_CRC'(1);
        top = MAX_CRC'(1) << (cw - 1);
        for (int k = MAX_DAT - 1; k >= 0; k--) begin
            if (k < dw) begin
                fb = (|(r & top)) ^ d[k];
                r  = ((r << 1) & msk) ^ (fb ? poly : '0);
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/ippcrc_crc_step.sv
// ippcrc_crc_step: combinational unrolled CRC step; in cur[CRC_W], dat[DAT_W]; out nxt[CRC_W]
module ippcrc_crc_step import ippcrc_pkg::*; #(
    parameter int              CRC_W     = 12,
    parameter int              DAT_W     = 8,
    parameter logic [CRC_W-1:0] POLY     = CRC_W'(CRC12_POLY),
    parameter bit              LSB_FIRST = 1'b1
) (
    input  logic [CRC_W-1:0] cur,
    input  logic [DAT_W-1:0] dat,
    output logic [CRC_W-1:0] nxt
);
    logic [MAX_DAT-1:0] d;
    always_comb begin
        d   = LSB_FIRST ? bitswap(MAX_DAT'(dat), DAT_W) : MAX_DAT'(dat);
        nxt = CRC_W'(crc_step(MAX_CRC'(cur), d, CRC_W, DAT_W, MAX_CRC'(POLY)));
    end
endmodule

// File: rtl/ippcrc_crc_mch.sv
// ippcrc_crc_mch: multi-channel CRC gen/check; in clk rst_n i_vld i_sop i_eop i_chn i_dat i_exp; out o_vld o_chn o_crc o_match o_seqerr
module ippcrc_crc_mch import ippcrc_pkg::*; #(
    parameter int               CRC_W     = 12,
    parameter int               DAT_W     = 8,
    parameter logic [CRC_W-1:0] POLY      = CRC_W'(CRC12_POLY),
    parameter logic [CRC_W-1:0] INIT      = '0,
    parameter logic [CRC_W-1:0] XOROUT    = '0,
    parameter bit               LSB_FIRST = 1'b1,
    parameter int               NCH       = 4,
    parameter int               CHN_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vld,
    input  logic             i_sop,
    input  logic             i_eop,
    input  logic [CHN_W-1:0] i_chn,
    input  logic [DAT_W-1:0] i_dat,
    input  logic [CRC_W-1:0] i_exp,
    output logic             o_vld,
    output logic [CHN_W-1:0] o_chn,
    output logic [CRC_W-1:0] o_crc,
    output logic             o_match,
    output logic             o_seqerr
);
    logic [CRC_W-1:0] st [NCH];
    logic [NCH-1:0]   opn;
    logic             in_rng, is_open, seqerr, beat, fin;
    logic [CRC_W-1:0] cur, nxt, res;
    always_comb begin
        in_rng  = int'(i_chn) < NCH;
        is_open = in_rng ? opn[i_chn] : 1'b0;
        beat    = i_vld & in_rng;
        fin     = beat & i_eop;
        seqerr  = i_vld & (~in_rng | (i_sop ~^ is_open));
        cur     = (i_sop | ~in_rng) ? INIT : st[i_chn];
        res     = nxt ^ XOROUT;
    end
    ippcrc_crc_step #(.CRC_W(CRC_W), .DAT_W(DAT_W), .POLY(POLY), .LSB_FIRST(LSB_FIRST)) u_step (
        .cur(cur),
        .dat(i_dat),
        .nxt(nxt)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) st[i] <= INIT;
            opn      <= '0;
            o_vld    <= 1'b0;
            o_chn    <= '0;
            o_crc    <= '0;
            o_match  <= 1'b0;
            o_seqerr <= 1'b0;
        end else begin
            o_vld    <= fin;
            o_match  <= fin & (res == i_exp);
            o_seqerr <= seqerr;
            if (beat) begin
                st[i_chn]  <= nxt;
                opn[i_chn] <= ~i_eop;
            end
            if (fin) o_crc <= res;
            if (fin | seqerr) o_chn <= i_chn;
        end
    end
endmodule

// File: tb/tb_ippcrc_crc_mch.sv
// tb_ippcrc_crc_mch: directed and randomized checks of ippcrc_crc_mch against a serial wire-order CRC model
module tb_ippcrc_crc_mch;
    logic clk = 1'b0, rst_n = 1'b0, vld = 1'b0, sop = 1'b0, eop = 1'b0;
    logic [1:0]  chn = '0;
    logic [31:0] dat = '0;
    logic [11:0] e0 = '0;
    logic [31:0] ex [3];
    logic u0_vld, u0_match, u0_err, u1_vld, u1_match, u1_err;
    logic [1:0] u0_chn, u1_chn;
    logic [11:0] u0_crc, u1_crc;
    logic r0_vld, r0_match, r0_err, r1_vld, r1_match, r1_err, r2_vld, r2_match, r2_err;
    logic [1:0] r0_chn, r1_chn, r2_chn;
    logic [11:0] r0_crc;
    logic [15:0] r1_crc;
    logic [31:0] r2_crc;
    int nchk = 0, nerr = 0;

    always #5 clk = ~clk;

    ippcrc_crc_mch u0 (.clk(clk), .rst_n(rst_n), .i_vld(vld), .i_sop(sop), .i_eop(eop), .i_chn(chn),
        .i_dat(dat[7:0]), .i_exp(e0), .o_vld(u0_vld), .o_chn(u0_chn), .o_crc(u0_crc),
        .o_match(u0_match), .o_seqerr(u0_err));
    ippcrc_crc_mch #(.NCH(3), .CHN_W(2)) u1 (.clk(clk), .rst_n(rst_n), .i_vld(vld), .i_sop(sop), .i_eop(eop),
        .i_chn(chn), .i_dat(dat[7:0]), .i_exp(e0), .o_vld(u1_vld), .o_chn(u1_chn), .o_crc(u1_crc),
        .o_match(u1_match), .o_seqerr(u1_err));
    ippcrc_crc_mch #(.CRC_W(12), .DAT_W(8), .POLY(12'h80F), .INIT(12'hFFF), .XOROUT(12'hFFF), .LSB_FIRST(1'b1))
        r0 (.clk(clk), .rst_n(rst_n), .i_vld(vld), .i_sop(sop), .i_eop(eop), .i_chn(chn), .i_dat(dat[7:0]),
        .i_exp(ex[0][11:0]), .o_vld(r0_vld), .o_chn(r0_chn), .o_crc(r0_crc), .o_match(r0_match), .o_seqerr(r0_err));
    ippcrc_crc_mch #(.CRC_W(16), .DAT_W(8), .POLY(16'h1021), .INIT(16'hFFFF), .XOROUT(16'hFFFF), .LSB_FIRST(1'b0))
        r1 (.clk(clk), .rst_n(rst_n), .i_vld(vld), .i_sop(sop), .i_eop(eop), .i_chn(chn), .i_dat(dat[7:0]),
        .i_exp(ex[1][15:0]), .o_vld(r1_vld), .o_chn(r1_chn), .o_crc(r1_crc), .o_match(r1_match), .o_seqerr(r1_err));
    ippcrc_crc_mch #(.CRC_W(32), .DAT_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF),
        .LSB_FIRST(1'b1))
        r2 (.clk(clk), .rst_n(rst_n), .i_vld(vld), .i_sop(sop), .i_eop(eop), .i_chn(chn), .i_dat(dat),
        .i_exp(ex[2]), .o_vld(r2_vld), .o_chn(r2_chn), .o_crc(r2_crc), .o_match(r2_match), .o_seqerr(r2_err));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Serial CRC over the bits in the order they appear on the wire.
    function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [31:0] d, input int cw,
                                            input int dw, input bit lsb, input logic [31:0] poly);
        logic [31:0] msk = (cw == 32) ? 32'hFFFFFFFF : ((32'd1 << cw) - 32'd1);
        logic [31:0] r = c;
        for (int i = 0; i < dw; i++) begin
            bit b = lsb ? d[i] : d[dw-1-i];
            bit t = r[cw-1] ^ b;
            r = ((r << 1) & msk) ^ (t ? poly : 32'd0);
        end
        return r;
    endfunction

    function automatic logic [31:0] c12(input logic [31:0] c, input logic [7:0] d);
        return crc_ref(c, {24'd0, d}, 12, 8, 1'b1, 32'h80F);
    endfunction

    task automatic beat(input bit s, input bit e, input logic [1:0] c, input logic [31:0] d, input logic [11:0] x);
        vld = 1'b1; sop = s; eop = e; chn = c; dat = d; e0 = x;
        @(posedge clk); #1;
        vld = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int cw_t [3] = '{12, 16, 32};
    int dw_t [3] = '{8, 8, 32};
    bit lsb_t [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] poly_t [3] = '{32'h80F, 32'h1021, 32'h04C11DB7};
    logic [31:0] ones_t [3] = '{32'hFFF, 32'hFFFF, 32'hFFFFFFFF};
    logic [31:0] mc [3][4];
    bit open_t [4];
    logic [31:0] rcrc [3], want [3];
    logic rvld [3], rmatch [3], rerr [3];
    logic [1:0] rchn [3];
    bit coin [3];

    always_comb begin
        rcrc[0] = {20'd0, r0_crc}; rcrc[1] = {16'd0, r1_crc}; rcrc[2] = r2_crc;
        rvld[0] = r0_vld; rvld[1] = r1_vld; rvld[2] = r2_vld;
        rmatch[0] = r0_match; rmatch[1] = r1_match; rmatch[2] = r2_match;
        rerr[0] = r0_err; rerr[1] = r1_err; rerr[2] = r2_err;
        rchn[0] = r0_chn; rchn[1] = r1_chn; rchn[2] = r2_chn;
    end

    initial begin
        int frames;
        bit s, e;
        logic [1:0] c;
        logic [31:0] d, cur;
        for (int k = 0; k < 3; k++) ex[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", 32'(u0_vld), 0);
        check("rst_crc", 32'(u0_crc), 0);
        check("rst_chn", 32'(u0_chn), 0);
        check("rst_match", 32'(u0_match), 0);
        check("rst_err", 32'(u0_err), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        beat(1, 1, 2'd0, 32'h80, 12'h000);
        check("b80_vld", 32'(u0_vld), 1);
        check("b80_chn", 32'(u0_chn), 0);
        check("b80_crc", 32'(u0_crc), 32'h80F);
        check("b80_err", 32'(u0_err), 0);
        beat(1, 1, 2'd1, 32'h01, 12'hD05);
        check("b01_crc", 32'(u0_crc), 32'hD05);
        check("b01_chn", 32'(u0_chn), 1);
        check("b01_match", 32'(u0_match), 1);
        beat(1, 1, 2'd1, 32'h01, 12'hD04);
        check("b01_vld", 32'(u0_vld), 1);
        check("b01_nomatch", 32'(u0_match), 0);
        @(posedge clk); #1;
        check("idle_vld", 32'(u0_vld), 0);
        check("idle_hold", 32'(u0_crc), 32'hD05);

        beat(1, 0, 2'd2, 32'h01, 12'h000);
        check("il_a_vld", 32'(u0_vld), 0);
        beat(1, 1, 2'd3, 32'h80, 12'h000);
        check("il_b_chn", 32'(u0_chn), 3);
        check("il_b_crc", 32'(u0_crc), 32'h80F);
        beat(0, 1, 2'd2, 32'h00, 12'h000);
        check("il_c_chn", 32'(u0_chn), 2);
        check("il_c_crc", 32'(u0_crc), c12(c12(0, 8'h01), 8'h00));
        check("il_c_err", 32'(u0_err), 0);

        beat(1, 0, 2'd0, 32'h55, 12'h000);
        check("sq_a_err", 32'(u0_err), 0);
        beat(1, 0, 2'd0, 32'hA3, 12'h000);
        check("sq_b_err", 32'(u0_err), 1);
        check("sq_b_chn", 32'(u0_chn), 0);
        beat(0, 1, 2'd0, 32'h3C, 12'h000);
        check("sq_c_vld", 32'(u0_vld), 1);
        check("sq_c_crc", 32'(u0_crc), c12(c12(0, 8'hA3), 8'h3C));

        beat(1, 1, 2'd3, 32'h80, 12'h000);
        check("oor_err", 32'(u1_err), 1);
        check("oor_vld", 32'(u1_vld), 0);
        check("oor_chn", 32'(u1_chn), 3);

        beat(1, 0, 2'd1, 32'h12, 12'h000);
        rst_n = 1'b0;
        #3;
        check("mid_rst_vld", 32'(u0_vld), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        beat(0, 1, 2'd1, 32'h34, 12'h000);
        check("mid_err", 32'(u0_err), 1);
        check("mid_vld", 32'(u0_vld), 1);
        check("mid_crc", 32'(u0_crc), c12(0, 8'h34));

        do_reset();
        for (int i = 0; i < 4; i++) open_t[i] = 1'b0;
        frames = 0;
        while (frames < 10000) begin
            if ($urandom_range(3) == 0) begin
                @(posedge clk); #1;
                for (int k = 0; k < 3; k++) begin
                    check("rnd_idle_vld", 32'(rvld[k]), 0);
                    check("rnd_idle_err", 32'(rerr[k]), 0);
                end
            end else begin
                c = 2'($urandom_range(3));
                s = !open_t[c];
                e = ($urandom_range(3) == 0);
                d = $urandom;
                open_t[c] = !e;
                for (int k = 0; k < 3; k++) begin
                    cur = s ? ones_t[k] : mc[k][c];
                    mc[k][c] = crc_ref(cur, d, cw_t[k], dw_t[k], lsb_t[k], poly_t[k]);
                    want[k] = mc[k][c] ^ ones_t[k];
                    coin[k] = $urandom_range(1) == 1;
                    ex[k] = coin[k] ? want[k] : want[k] ^ 32'd1;
                end
                vld = 1'b1; sop = s; eop = e; chn = c; dat = d;
                @(posedge clk); #1;
                vld = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    check("rnd_vld", 32'(rvld[k]), 32'(e));
                    check("rnd_err", 32'(rerr[k]), 0);
                    if (e) begin
                        check("rnd_crc", rcrc[k], want[k]);
                        check("rnd_chn", 32'(rchn[k]), 32'(c));
                        check("rnd_match", 32'(rmatch[k]), 32'(coin[k]));
                    end
                end
                if (e) frames++;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
